// File: rtl/eager_join_dataless.sv
// eager_join_dataless: dataless N-to-1 synchronizing join with eager absorption.
// Each input has a one-slot "arrived" flag. A token is taken as soon as it
// shows up, whatever the other inputs or the consumer are doing. The joined
// output token fires once every input has a token, either held in its flag
// or presented in this cycle.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   ins_valid   [SIZE] per-input valid
//   ins_ready   [SIZE] per-input ready (depends only on the held flags)
//   outs_valid  joined output valid (combinational from ins_valid)
//   outs_ready  downstream ready
module eager_join_dataless #(
  parameter int unsigned SIZE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] ins_valid,
  output logic [SIZE-1:0] ins_ready,
  output logic            outs_valid,
  input  logic            outs_ready
);

  logic [SIZE-1:0] held;
  logic [SIZE-1:0] present;
  logic            all_present;
  logic            fire;

  // An input counts as present if its token is held or arrives now.
  assign present     = held | ins_valid;
  assign all_present = &present;
  assign outs_valid  = all_present & ~rst;
  assign fire        = outs_valid & outs_ready;

  // Ready comes only from registered flags, so outs_ready never reaches ins_ready.
  assign ins_ready   = ~held & {SIZE{~rst}};

  // One arrived flag per input. Tokens arriving in the fire cycle are consumed
  // directly and never stored.
  for (genvar i = 0; i < int'(SIZE); i++) begin : g_slot
    logic held_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        held_q <= 1'b0;
      end else if (fire) begin
        held_q <= 1'b0;
      end else begin
        held_q <= present[i];
      end
    end

    assign held[i] = held_q;
  end

endmodule

// File: tb/tb_eager_join_dataless.sv
// Bench for eager_join_dataless: a SIZE=2 and a SIZE=3 instance, directed
// scenarios with literal expectations plus constrained-random traffic. Both
// are checked every cycle against a token-count model of the join.
module tb_eager_join_dataless;

  logic       clk;
  logic       rst;
  logic [1:0] v2, r2;
  logic       ov2, or2;
  logic [2:0] v3, r3;
  logic       ov3, or3;

  int checks = 0;
  int errors = 0;
  // Model: tokens accepted on each input and not yet joined, per instance.
  int cnt[2][3];
  int dfires[2];

  eager_join_dataless #(.SIZE(2)) dut2 (
    .clk(clk), .rst(rst), .ins_valid(v2), .ins_ready(r2),
    .outs_valid(ov2), .outs_ready(or2)
  );

  eager_join_dataless #(.SIZE(3)) dut3 (
    .clk(clk), .rst(rst), .ins_valid(v3), .ins_ready(r3),
    .outs_valid(ov3), .outs_ready(or3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Token-conservation model: an input is ready only while it owes no token
  // to a pending join; the output is valid when every input owes or offers one.
  task automatic model(input int k, input int n, input logic [2:0] v,
                       input logic [2:0] r, input logic ov, input logic ordy);
    logic [2:0] er;
    bit         all_in;
    bit         eov;
    bit         fire;
    er     = '0;
    all_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      er[i] = (cnt[k][i] == 0) && !rst;
      if (cnt[k][i] == 0 && !v[i]) all_in = 1'b0;
    end
    eov = all_in && !rst;
    chk($sformatf("model_ins_ready_%0d", k), int'(r), int'(er));
    chk($sformatf("model_outs_valid_%0d", k), int'(ov), int'(eov));
    if (ov && ordy) dfires[k]++;
    if (rst) begin
      for (int i = 0; i < 3; i++) cnt[k][i] = 0;
    end else begin
      fire = eov && ordy;
      for (int i = 0; i < n; i++) begin
        if (v[i] && er[i]) cnt[k][i]++;
        if (fire) cnt[k][i]--;
        if (cnt[k][i] < 0 || cnt[k][i] > 1) begin
          chk($sformatf("model_slot_count_%0d_%0d", k, i), cnt[k][i], 1);
          cnt[k][i] = 0;
        end
      end
    end
  endtask

  // Single compare process for both instances, sampled away from the active edge.
  always @(negedge clk) begin
    model(0, 2, {1'b0, v2}, {1'b0, r2}, ov2, or2);
    model(1, 3, v3, r3, ov3, or3);
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int f0;
    logic [1:0] ov_tab [5];
    logic [1:0] rd_tab [5];
    logic [2:0] v3_tab [7];
    logic [2:0] r3_tab [7];
    logic       o3_tab [7];
    logic [1:0] s2;
    logic [2:0] s3;

    for (int k = 0; k < 2; k++) begin
      dfires[k] = 0;
      for (int i = 0; i < 3; i++) cnt[k][i] = 0;
    end

    // Reset: outputs forced low regardless of inputs.
    rst = 1'b1; v2 = 2'b11; or2 = 1'b1; v3 = 3'b000; or3 = 1'b0;
    @(negedge clk);
    chk("rst_outs_valid", int'(ov2), 0);
    chk("rst_ins_ready", int'(r2), 0);
    nxt();
    rst = 1'b0; v2 = 2'b00;
    @(negedge clk);
    chk("post_rst_ins_ready", int'(r2), 3);
    nxt();

    // Simultaneous arrival: four back-to-back fires, flags stay clear.
    f0 = dfires[0];
    v2 = 2'b11; or2 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("sim_outs_valid", int'(ov2), 1);
      chk("sim_ins_ready", int'(r2), 3);
      nxt();
    end
    v2 = 2'b00;
    chk("sim_fire_count", dfires[0] - f0, 4);
    @(negedge clk);
    chk("sim_after_ready", int'(r2), 3);
    nxt();

    // Staggered arrival.
    v2 = 2'b01;
    @(negedge clk);
    chk("stag_c0_outs_valid", int'(ov2), 0);
    nxt();
    v2 = 2'b10;
    @(negedge clk);
    chk("stag_c1_ins_ready", int'(r2), 2);
    chk("stag_c1_outs_valid", int'(ov2), 1);
    nxt();
    v2 = 2'b00;
    @(negedge clk);
    chk("stag_c2_ins_ready", int'(r2), 3);
    chk("stag_c2_outs_valid", int'(ov2), 0);
    nxt();

    // Repeat on one input: input0 valid every cycle, input1 only at cycle 3.
    ov_tab = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
    rd_tab = '{2'd3, 2'd2, 2'd2, 2'd2, 2'd3};
    f0 = dfires[0];
    for (int c = 0; c < 5; c++) begin
      v2 = (c == 3) ? 2'b11 : 2'b01;
      @(negedge clk);
      chk($sformatf("rep_c%0d_outs_valid", c), int'(ov2), int'(ov_tab[c]));
      chk($sformatf("rep_c%0d_ins_ready", c), int'(r2), int'(rd_tab[c]));
      nxt();
    end
    chk("rep_fire_count", dfires[0] - f0, 1);
    // Drain the token input0 took at cycle 4.
    v2 = 2'b10;
    @(negedge clk);
    chk("rep_drain_outs_valid", int'(ov2), 1);
    nxt();
    v2 = 2'b00;

    // Reset mid-operation discards held tokens.
    f0 = dfires[0];
    v2 = 2'b01;
    nxt();
    rst = 1'b1; v2 = 2'b10;
    @(negedge clk);
    chk("midrst_outs_valid", int'(ov2), 0);
    chk("midrst_ins_ready", int'(r2), 0);
    nxt();
    rst = 1'b0; v2 = 2'b00;
    @(negedge clk);
    chk("midrst_after_ready", int'(r2), 3);
    chk("midrst_after_outs_valid", int'(ov2), 0);
    nxt();
    v2 = 2'b11;
    @(negedge clk);
    chk("midrst_new_outs_valid", int'(ov2), 1);
    nxt();
    v2 = 2'b00;
    chk("midrst_fire_count", dfires[0] - f0, 1);

    // Consumer stall on the 3-input join.
    v3_tab = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
    r3_tab = '{3'b111, 3'b110, 3'b100, 3'b000, 3'b000, 3'b000, 3'b111};
    o3_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    f0 = dfires[1];
    for (int c = 0; c < 7; c++) begin
      v3  = v3_tab[c];
      or3 = (c >= 5);
      @(negedge clk);
      chk($sformatf("stall_c%0d_outs_valid", c), int'(ov3), int'(o3_tab[c]));
      chk($sformatf("stall_c%0d_ins_ready", c), int'(r3), int'(r3_tab[c]));
      nxt();
    end
    chk("stall_fire_count", dfires[1] - f0, 1);
    v3 = 3'b000; or3 = 1'b0;

    // Random traffic; a valid stays up until it transfers.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      s2 = v2 & ~r2;
      s3 = v3 & ~r3;
      nxt();
      for (int i = 0; i < 2; i++) v2[i] = s2[i] | 1'($urandom_range(0, 1));
      for (int i = 0; i < 3; i++) v3[i] = s3[i] | 1'($urandom_range(0, 1));
      or2 = ($urandom_range(0, 3) != 0);
      or3 = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 63) == 0);
    end
    rst = 1'b0;
    @(negedge clk);
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
